multu_hilo: RTL

- Consumer end of the ALU control signal bus for multiply and HiLo operations.
- Watches the 6-bit control word; on MULTU it latches both operands and runs a 32-step unsigned shift-add multiply.
- Commits the 64-bit product into Hi/Lo only when the controller issues the HiLo-write code (6'b111111).
- Serves MFHI/MFLO reads to the datapath output mux.

---
 rtl/multu_hilo.sv | 136 +++++++++++++
 1 files changed

// File: rtl/multu_hilo.sv
// Unsigned shift-add multiplier on the ALU control bus; MULTU loads then steps once per edge, HiLo-write commits to Hi/Lo.
// Latency: load edge + WIDTH step edges, commit on next HILO_WR edge; no backpressure, any off-sequence code aborts to IDLE.
module multu_hilo #(
    parameter int         WIDTH        = 32,
    parameter logic [5:0] MULTU_CODE   = 6'b011001,
    parameter logic [5:0] MFHI_CODE    = 6'b010000,
    parameter logic [5:0] MFLO_CODE    = 6'b010010,
    parameter logic [5:0] HILO_WR_CODE = 6'b111111
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic [5:0]       Signal,
    output logic [WIDTH-1:0] dataOut,
    output logic             busy,
    output logic             done
);

    localparam int            CW    = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] STEPS = CW'(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_WAIT_WR = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_nxt_state;
    logic [WIDTH-1:0]     r_mcand;
    logic [2*WIDTH-1:0]   r_prod;
    logic [CW-1:0]        r_cnt;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_done;

    logic                 w_load;
    logic                 w_step;
    logic                 w_commit;
    logic [CW-1:0]        w_cnt_inc;
    logic [WIDTH:0]       w_addend;
    logic [WIDTH:0]       w_sum;

    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_addend  = r_prod[0] ? {1'b0, r_mcand} : '0;
    // Upper half plus conditional multiplicand; the carry bit is kept by the shift below.
    assign w_sum     = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + w_addend;

    always_comb begin
        w_nxt_state = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (Signal == MULTU_CODE) begin
                    w_load      = 1'b1;
                    w_nxt_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (Signal == MULTU_CODE) begin
                    w_step = 1'b1;
                    if (w_cnt_inc == STEPS) begin
                        w_nxt_state = ST_WAIT_WR;
                    end
                end else begin
                    w_nxt_state = ST_IDLE;
                end
            end
            ST_WAIT_WR: begin
                if (Signal == HILO_WR_CODE) begin
                    w_commit    = 1'b1;
                    w_nxt_state = ST_IDLE;
                end else if (Signal != MULTU_CODE) begin
                    w_nxt_state = ST_IDLE;
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mcand <= '0;
            r_prod  <= '0;
            r_cnt   <= '0;
        end else if (w_load) begin
            r_mcand <= dataA;
            r_prod  <= {{WIDTH{1'b0}}, dataB};
            r_cnt   <= '0;
        end else if (w_step) begin
            r_prod  <= {w_sum, r_prod[WIDTH-1:1]};
            r_cnt   <= w_cnt_inc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_commit;
            if (w_commit) begin
                r_hi <= r_prod[2*WIDTH-1:WIDTH];
                r_lo <= r_prod[WIDTH-1:0];
            end
        end
    end

    // Only committed Hi/Lo are visible; partial products never reach the datapath.
    always_comb begin
        dataOut = '0;
        if (Signal == MFHI_CODE) begin
            dataOut = r_hi;
        end else if (Signal == MFLO_CODE) begin
            dataOut = r_lo;
        end
    end

    assign busy = (r_state == ST_RUN) || (r_state == ST_WAIT_WR);
    assign done = r_done;

endmodule
